// File: rtl/khani_sort_stream.sv
// Streaming frame sorter: loads N samples while ranking them incrementally,
// inverts the ranks into a permutation, then emits the frame in ascending order.
module khani_sort_stream #(
    parameter int N     = 6,
    parameter int WIDTH = 8,
    parameter int IDXW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [IDXW-1:0]  m_index,
    output logic             m_last
);
    typedef enum logic [1:0] {LOAD, RANK, EMIT} state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t           state;
    logic [IDXW-1:0]  in_cnt;
    logic [IDXW-1:0]  rank_cnt;
    logic [IDXW-1:0]  out_idx;

    logic [WIDTH-1:0] data [N];
    logic [IDXW-1:0]  rank [N];
    logic [IDXW-1:0]  perm [N];

    logic [IDXW-1:0]  new_rank;
    logic [N-1:0]     bump;
    logic             in_fire;
    logic             out_fire;

    assign s_ready  = (state == LOAD);
    assign m_valid  = (state == EMIT);
    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid && m_ready;

    assign m_data  = m_valid ? data[perm[out_idx]] : '0;
    assign m_index = m_valid ? perm[out_idx] : '0;
    assign m_last  = m_valid && (out_idx == LAST);

    // Earlier equal samples stay below the newcomer, which keeps ties stable.
    always_comb begin
        new_rank = '0;
        bump     = '0;
        for (int j = 0; j < N; j++) begin
            if (j < int'(in_cnt)) begin
                if (data[j] <= s_data)
                    new_rank = new_rank + IDXW'(1);
                else
                    bump[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            in_cnt   <= '0;
            rank_cnt <= '0;
            out_idx  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (in_cnt == LAST) begin
                            in_cnt   <= '0;
                            rank_cnt <= '0;
                            state    <= RANK;
                        end else begin
                            in_cnt <= in_cnt + IDXW'(1);
                        end
                    end
                end
                RANK: begin
                    if (rank_cnt == LAST) begin
                        rank_cnt <= '0;
                        out_idx  <= '0;
                        state    <= EMIT;
                    end else begin
                        rank_cnt <= rank_cnt + IDXW'(1);
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_idx == LAST) begin
                            out_idx <= '0;
                            state   <= LOAD;
                        end else begin
                            out_idx <= out_idx + IDXW'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Sample/rank/permutation storage carries no reset; every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            data[in_cnt] <= s_data;
            rank[in_cnt] <= new_rank;
            for (int j = 0; j < N; j++) begin
                if (bump[j])
                    rank[j] <= rank[j] + IDXW'(1);
            end
        end
        if (state == RANK)
            perm[rank[rank_cnt]] <= rank_cnt;
    end

endmodule
